keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//  Input-side counterpart of the 4-digit seven-segment output path. Scans a 4x4 matrix keypad,
//  debounces it, and builds a decimal number of up to 4 digits (0-9999). The number is handed to
//  the RISC-V top as a 16-bit binary value through a valid/ack handshake. While a number is being
//  typed, preview_value carries it so the display driver can echo it.
// PARAMETERS
//  SCAN_CYCLES      100_000    clocks each column is driven low (1 ms @100 MHz); must be >= 4
//  DEBOUNCE_CYCLES  2_000_000  clocks a press or release must stay stable (20 ms)
//  MAX_DIGITS       4          digits accepted per entry (1..4)
//  REPEAT_DELAY     50_000_000 clocks before first auto-repeat (used only with KEYPAD_AUTOREPEAT_EN)
//  REPEAT_PERIOD    10_000_000 clocks between later auto-repeats (used only with KEYPAD_AUTOREPEAT_EN)
// PORTS
//  clk_100mhz     in   1   single system clock
//  reset          in   1   asynchronous, active-low reset
//  row_in         in   4   keypad rows, active-low, externally pulled up; asynchronous to the clock
//  col_out        out  4   keypad columns, one-cold drive
//  key_strobe     out  1   1-cycle pulse per accepted key event
//  key_code       out  4   last accepted key, encoded row*4+col
//  preview_value  out  16  accumulator being typed
//  digit_count    out  3   digits in the accumulator
//  entry_value    out  16  committed number; stable while entry_valid is high
//  entry_valid    out  1   committed number available; held high until entry_ack
//  entry_ack      in   1   consumer accepts entry_value
// BEHAVIOUR
//  Reset values: col_out=4'b1111, key_strobe=0, key_code=0, preview_value=0, digit_count=0,
//   entry_value=0, entry_valid=0, FSM=SCAN with col=0.
//  Reset mid-operation (press, debounce or pending entry) discards all state immediately.
//  row_in passes through a 2-FF synchronizer. Rows are sampled only on the last cycle of a column dwell.
//  Keypad layout by row: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
//  FSM:
//   SCAN: drive col_out = ~(1<<col) for SCAN_CYCLES, then sample the rows.
//    All rows high: col = col+1 mod 4.
//    Any row low: latch the lowest-index low row and col, then go to DEBOUNCE (col stays driven).
//   DEBOUNCE: the latched row must stay low for DEBOUNCE_CYCLES consecutive clocks.
//    Any high sample: go back to SCAN at the same col with no event.
//    Count reached: pulse key_strobe and load key_code, then go to HOLD.
//   HOLD: all rows must stay high for DEBOUNCE_CYCLES consecutive clocks.
//    Any low sample restarts that count. When the count is reached, go to SCAN at col+1.
//  Accumulator: updates on the clock edge after key_strobe.
//   Digit 0-9: if digit_count<MAX_DIGITS then preview=preview*10+d and digit_count+1;
//    otherwise the digit is ignored.
//   '*' (backspace): preview=preview/10 and digit_count-1; no-op when digit_count=0.
//   'C' (clear): preview=0, digit_count=0.
//   '#' (enter): if digit_count>0 and entry_valid=0, load entry_value=preview, set entry_valid=1,
//    and clear the accumulator. Otherwise (empty accumulator, or pending entry) it is ignored and
//    the accumulator is kept.
//   A, B, D: key_strobe still pulses, no accumulator effect.
//  Handshake: entry_valid falls on the edge where entry_ack=1.
//   If entry_ack and an accepted enter occur in the same cycle, the new entry wins:
//    entry_valid stays 1 and entry_value takes the new value.
//   entry_ack while entry_valid=0 is ignored.
//  Arithmetic: a 4-digit maximum of 9999 fits in 16 bits; multiply-by-10 is computed at 17 bits,
//   no wrap is possible.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined: in HOLD with the key still down, re-emit key_strobe (same
//   key_code) after REPEAT_DELAY clocks, then every REPEAT_PERIOD clocks. Applies to digits and
//   '*' only; '#' and 'C' never repeat. Each repeat is processed as a fresh key event.
//  Not defined: exactly one event per press; REPEAT_* are unused and no repeat counters are built.
// TESTING  (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
//  Reset held low: col_out=4'b1111 and all outputs 0. After release, col_out cycles
//   1110,1101,1011,0111 with 4 clocks per column.
//  Press keys 4,2,0,7 then '#' -> preview 4, 42, 420, 4207; then entry_valid=1, entry_value=4207,
//   preview=0, digit_count=0.
//  Row glitch of 3 clocks on '5' -> no key_strobe. Bouncing release of '5' (low 2 clk, high 3 clk,
//   low 2 clk, then stable high) -> exactly one strobe.
//  Enter 9999, then press '1' -> ignored, preview stays 9999. Then '*' -> 999; 'C' -> 0;
//   '#' with empty accumulator -> ignored.
//  Entry 12 pending, type 34 + '#' without ack -> entry_value stays 12, preview stays 34.
//   Ack -> valid drops; second '#' commits 34.
//  Reset asserted during DEBOUNCE with entry_valid=1 -> all outputs back to reset values within
//   the same cycle; no strobe after release.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 matrix keypad, debounces presses and releases, and
// assembles a decimal number of up to MAX_DIGITS digits for a valid/ack consumer.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of digits and '*' while held).
module keypad_entry #(
  parameter int SCAN_CYCLES     = 100_000,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MAX_DIGITS      = 4,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] preview_value,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_value,
  output logic        entry_valid,
  input  logic        entry_ack
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]        DIGIT_MAX = 3'(MAX_DIGITS);

  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_STAR  = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;

  // Reject configurations the scanner and accumulator cannot support.
  generate
    if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 1 || MAX_DIGITS < 1 || MAX_DIGITS > 4 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keypad_entry: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } state_t;

  state_t            state, state_next;
  logic [1:0]        col, col_next;
  logic [1:0]        row_sel, row_sel_next;
  logic [1:0]        low_row;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_next;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic              strobe_next;
  logic              drive_en;
  logic [3:0]        row_meta, row_sync;

  logic              is_digit;
  logic [3:0]        digit_val;
  logic [16:0]       times_ten;
  logic              accept_enter;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_next;
  logic             rep_first, rep_first_next;
  logic             repeatable;

  // Digits and '*' repeat; the letter column and '#' never do.
  assign repeatable = (col != 2'd3) && ({row_sel, col} != KEY_ENTER);
`endif

  // Two-flop synchronizer for the asynchronous keypad rows (idle level is high).
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Columns stay released until the first clock after reset, then one is driven low.
  always_comb begin
    col_out = 4'b1111;
    if (drive_en) begin
      col_out = ~(4'b0001 << col);
    end
  end

  // Pick the lowest-index row currently pulled low.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) begin
        low_row = 2'(i);
      end
    end
  end

  // Scan / debounce / hold next-state logic and key event generation.
  always_comb begin
    state_next    = state;
    col_next      = col;
    row_sel_next  = row_sel;
    scan_cnt_next = scan_cnt;
    db_cnt_next   = db_cnt;
    strobe_next   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_next   = rep_cnt;
    rep_first_next = rep_first;
`endif
    case (state)
      SCAN: begin
        if (drive_en) begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt_next = '0;
            if (row_sync == 4'hF) begin
              col_next = col + 2'd1;
            end else begin
              row_sel_next = low_row;
              db_cnt_next  = '0;
              state_next   = DEBOUNCE;
            end
          end else begin
            scan_cnt_next = scan_cnt + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_sync[row_sel]) begin
          scan_cnt_next = '0;
          state_next    = SCAN;
        end else if (db_cnt == DB_LAST) begin
          strobe_next = 1'b1;
          db_cnt_next = '0;
          state_next  = HOLD;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (row_sync != 4'hF) begin
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt_next   = '0;
          scan_cnt_next = '0;
          col_next      = col + 2'd1;
          state_next    = SCAN;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
`ifdef KEYPAD_AUTOREPEAT_EN
    if (state != HOLD || row_sync[row_sel] || !repeatable) begin
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else if (rep_cnt == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
      rep_cnt_next   = '0;
      rep_first_next = 1'b0;
      strobe_next    = 1'b1;
    end else begin
      rep_cnt_next = rep_cnt + 1'b1;
    end
`endif
  end

  // Scanner state register; key_code is loaded together with each strobe.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      col        <= 2'd0;
      row_sel    <= 2'd0;
      scan_cnt   <= '0;
      db_cnt     <= '0;
      drive_en   <= 1'b0;
      key_strobe <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      state      <= state_next;
      col        <= col_next;
      row_sel    <= row_sel_next;
      scan_cnt   <= scan_cnt_next;
      db_cnt     <= db_cnt_next;
      drive_en   <= 1'b1;
      key_strobe <= strobe_next;
      if (strobe_next) begin
        key_code <= {row_sel, col};
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat timing registers.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_next;
      rep_first <= rep_first_next;
    end
  end
`endif

  // Map key codes of the digit keys to their decimal value.
  always_comb begin
    is_digit  = 1'b1;
    digit_val = 4'd0;
    case (key_code)
      4'd0:    digit_val = 4'd1;
      4'd1:    digit_val = 4'd2;
      4'd2:    digit_val = 4'd3;
      4'd4:    digit_val = 4'd4;
      4'd5:    digit_val = 4'd5;
      4'd6:    digit_val = 4'd6;
      4'd8:    digit_val = 4'd7;
      4'd9:    digit_val = 4'd8;
      4'd10:   digit_val = 4'd9;
      4'd13:   digit_val = 4'd0;
      default: is_digit  = 1'b0;
    endcase
  end

  // Shift a digit into the accumulator at 17 bits; the top bit guards against any overflow.
  always_comb begin
    times_ten    = 17'(preview_value) * 17'd10 + 17'(digit_val);
    accept_enter = key_strobe && (key_code == KEY_ENTER) && (digit_count != 3'd0) && !entry_valid;
  end

  // Accumulator: reacts one edge after each key strobe.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      preview_value <= 16'd0;
      digit_count   <= 3'd0;
    end else if (key_strobe) begin
      if (is_digit) begin
        if (digit_count < DIGIT_MAX && !times_ten[16]) begin
          preview_value <= times_ten[15:0];
          digit_count   <= digit_count + 3'd1;
        end
      end else if (key_code == KEY_STAR) begin
        if (digit_count != 3'd0) begin
          preview_value <= preview_value / 16'd10;
          digit_count   <= digit_count - 3'd1;
        end
      end else if (key_code == KEY_CLEAR || accept_enter) begin
        preview_value <= 16'd0;
        digit_count   <= 3'd0;
      end
    end
  end

  // Committed entry with valid/ack handshake; a fresh commit overrides a same-cycle ack.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      entry_value <= 16'd0;
      entry_valid <= 1'b0;
    end else if (accept_enter) begin
      entry_value <= preview_value;
      entry_valid <= 1'b1;
    end else if (entry_ack) begin
      entry_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: drives a simulated 4x4 keypad into keypad_entry and compares the
// accumulator and entry handshake with a decimal-entry reference model.
`timescale 1ns/1ps
module tb_keypad_entry;

  localparam int SCAN = 4;
  localparam int DB   = 8;

  logic        clk_100mhz = 1'b0;
  logic        reset      = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] preview_value;
  logic [2:0]  digit_count;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic        entry_ack = 1'b0;

  logic        key_down = 1'b0;
  logic [3:0]  key_sel  = 4'd0;

  int check_count  = 0;
  int error_count  = 0;
  int strobe_count = 0;

  int exp_preview = 0;
  int exp_count   = 0;
  int exp_value   = 0;
  bit exp_valid   = 0;

  byte layout [16] = '{"1", "2", "3", "A", "4", "5", "6", "B",
                       "7", "8", "9", "C", "*", "0", "#", "D"};

  keypad_entry #(
    .SCAN_CYCLES(SCAN),
    .DEBOUNCE_CYCLES(DB),
    .MAX_DIGITS(4),
    .REPEAT_DELAY(64),
    .REPEAT_PERIOD(16)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .key_strobe(key_strobe),
    .key_code(key_code),
    .preview_value(preview_value),
    .digit_count(digit_count),
    .entry_value(entry_value),
    .entry_valid(entry_valid),
    .entry_ack(entry_ack)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Keypad matrix: a held key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    if (key_down && !col_out[key_sel[1:0]]) begin
      row_in[key_sel[3:2]] = 1'b0;
    end
  end

  // Count every key event the design emits.
  always @(negedge clk_100mhz) begin
    if (key_strobe === 1'b1) begin
      strobe_count++;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Decimal-entry rules applied to one accepted key.
  task automatic modelKey(input logic [3:0] code);
    byte ch;
    ch = layout[code];
    if (ch >= "0" && ch <= "9") begin
      if (exp_count < 4) begin
        exp_preview = exp_preview * 10 + int'(ch - "0");
        exp_count++;
      end
    end else if (ch == "*") begin
      if (exp_count > 0) begin
        exp_preview = exp_preview / 10;
        exp_count--;
      end
    end else if (ch == "C") begin
      exp_preview = 0;
      exp_count   = 0;
    end else if (ch == "#") begin
      if (exp_count > 0 && !exp_valid) begin
        exp_value   = exp_preview;
        exp_valid   = 1;
        exp_preview = 0;
        exp_count   = 0;
      end
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, "_preview"}, preview_value, exp_preview);
    checkOutput({tag, "_count"}, digit_count, exp_count);
    checkOutput({tag, "_valid"}, entry_valid, exp_valid);
    checkOutput({tag, "_value"}, entry_value, exp_value);
  endtask

  // Press one key, wait for its event, then release (optionally with contact bounce).
  task automatic applyStimulus(input logic [3:0] code, input bit bounce);
    int start;
    bit seen;
    start = strobe_count;
    seen  = 0;
    @(negedge clk_100mhz);
    key_sel  = code;
    key_down = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_100mhz);
      if (key_strobe) begin
        seen = 1;
        break;
      end
    end
    checkOutput("strobe_seen", seen, 1);
    if (seen) begin
      checkOutput("key_code", key_code, code);
    end
    @(negedge clk_100mhz);
    modelKey(code);
    compareModel("key");
    if (bounce) begin
      repeat (2) @(negedge clk_100mhz);
      key_down = 1'b0;
      repeat (3) @(negedge clk_100mhz);
      key_down = 1'b1;
      repeat (2) @(negedge clk_100mhz);
    end else begin
      repeat ($urandom_range(0, 6)) @(negedge clk_100mhz);
    end
    key_down = 1'b0;
    repeat (DB + 8) @(negedge clk_100mhz);
    checkOutput("one_strobe", strobe_count - start, 1);
  endtask

  task automatic doAck();
    @(negedge clk_100mhz);
    entry_ack = 1'b1;
    @(negedge clk_100mhz);
    entry_ack = 1'b0;
    exp_valid = 0;
    checkOutput("ack_valid", entry_valid, 0);
  endtask

  // Return on the negedge where the given column pattern has just started its dwell.
  task automatic waitColumn(input logic [3:0] pattern);
    logic [3:0] prev;
    bit ok;
    prev = col_out;
    ok   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100mhz);
      if (col_out == pattern && prev != pattern) begin
        ok = 1;
        break;
      end
      prev = col_out;
    end
    checkOutput("col_align", ok, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_col"}, col_out, 4'b1111);
    checkOutput({tag, "_strobe"}, key_strobe, 0);
    checkOutput({tag, "_code"}, key_code, 0);
    checkOutput({tag, "_preview"}, preview_value, 0);
    checkOutput({tag, "_count"}, digit_count, 0);
    checkOutput({tag, "_value"}, entry_value, 0);
    checkOutput({tag, "_valid"}, entry_valid, 0);
  endtask

  initial begin
    logic [3:0] exp_col;
    logic [3:0] code;
    int start;

    repeat (3) @(negedge clk_100mhz);
    checkResetValues("reset");

    @(negedge clk_100mhz);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_100mhz);
      exp_col = ~(4'b0001 << (i / 4));
      checkOutput("col_scan", col_out, exp_col);
    end

    // Type 4 2 0 7 and commit.
    applyStimulus(4'd4, 0);
    applyStimulus(4'd1, 0);
    applyStimulus(4'd13, 0);
    applyStimulus(4'd8, 0);
    checkOutput("typed_4207", preview_value, 4207);
    applyStimulus(4'd14, 0);
    checkOutput("entry_4207", entry_value, 4207);
    checkOutput("entry_valid_4207", entry_valid, 1);

    // A short glitch on '5' must not produce an event.
    waitColumn(4'b1101);
    start    = strobe_count;
    key_sel  = 4'd5;
    key_down = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    key_down = 1'b0;
    repeat (40) @(negedge clk_100mhz);
    checkOutput("glitch_no_strobe", strobe_count - start, 0);
    compareModel("glitch");

    // Bouncing release of '5' gives exactly one event.
    applyStimulus(4'd5, 1);
    doAck();
    applyStimulus(4'd11, 0);

    // Full accumulator, ignored extra digit, backspace, clear, empty enter.
    repeat (4) applyStimulus(4'd10, 0);
    checkOutput("full_9999", preview_value, 9999);
    applyStimulus(4'd0, 0);
    checkOutput("ignored_digit", preview_value, 9999);
    applyStimulus(4'd12, 0);
    checkOutput("backspace_999", preview_value, 999);
    applyStimulus(4'd11, 0);
    checkOutput("clear_0", preview_value, 0);
    applyStimulus(4'd14, 0);
    checkOutput("empty_enter_valid", entry_valid, 0);

    // Pending entry blocks a second enter until acknowledged.
    applyStimulus(4'd0, 0);
    applyStimulus(4'd1, 0);
    applyStimulus(4'd14, 0);
    checkOutput("pending_12", entry_value, 12);
    applyStimulus(4'd2, 0);
    applyStimulus(4'd4, 0);
    applyStimulus(4'd14, 0);
    checkOutput("blocked_value", entry_value, 12);
    checkOutput("blocked_preview", preview_value, 34);
    doAck();
    applyStimulus(4'd14, 0);
    checkOutput("commit_34", entry_value, 34);
    doAck();

    // Random key sequence with occasional acknowledges.
    for (int n = 0; n < 40; n++) begin
      code = 4'($urandom_range(0, 15));
      applyStimulus(code, 0);
      if ($urandom_range(0, 3) == 0) begin
        doAck();
      end
    end

    // Reset while a key is being debounced and an entry is pending.
    doAck();
    applyStimulus(4'd5, 0);
    applyStimulus(4'd14, 0);
    checkOutput("pre_reset_valid", entry_valid, 1);
    waitColumn(4'b1011);
    start    = strobe_count;
    key_sel  = 4'd2;
    key_down = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    #1;
    reset = 1'b0;
    #1;
    checkResetValues("mid_reset");
    checkOutput("mid_reset_no_strobe", strobe_count - start, 0);
    exp_preview = 0;
    exp_count   = 0;
    exp_value   = 0;
    exp_valid   = 0;
    repeat (3) @(negedge clk_100mhz);
    key_down = 1'b0;
    @(negedge clk_100mhz);
    reset = 1'b1;
    repeat (60) @(negedge clk_100mhz);
    checkOutput("post_reset_no_strobe", strobe_count - start, 0);
    compareModel("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
